oric_ram_sequencer: RTL and testbench
=====================================

Name: oric_ram_sequencer

Overview:
- Front end for the single-port 64 KiB main RAM (dpram port 1) of the Oric sim/core top.
- Sits between the oricatmos RAM bus, the cassettecached tape writer and the RAM macro.
- Performs the power-on RAM clear sequence after reset.
- Arbitrates tape-image writes against CPU/video accesses, so tape loading no longer needs a second RAM port.

Parameters:
- AW, 16, RAM address width; clear length is 2^AW cycles.
- CLR_VALUE, 8'hFF, byte written to every location during clear.

Ports:
- clk_48  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_ad  in  AW  core RAM address
- cpu_d  in  8  core write data
- cpu_cs  in  1  core chip select
- cpu_we  in  1  core write enable (qualified by cpu_cs)
- cpu_q  out  8  read data to core
- tape_addr  in  AW  tape loader address
- tape_dout  in  8  tape loader data
- tape_wr  in  1  tape write strobe, one cycle per byte
- mem_a  out  AW  RAM address
- mem_d  out  8  RAM write data
- mem_ce  out  1  RAM chip enable
- mem_we  out  1  RAM write enable
- mem_q  in  8  RAM read data, valid 1 cycle after mem_a/mem_ce
- clr_busy  out  1  high while clearing; top ORs it into core reset
- tape_ovf  out  1  sticky: tape write lost
- rd_miss  out  8  saturating count of CPU reads displaced by arbitration

Behaviour:
- Reset is synchronous and active-high, clock clk_48.
- While reset is high:
  - state=CLEAR, counter=0, holding regs empty.
  - tape_ovf=0, rd_miss=0, clr_busy=1.
  - mem_ce=0, mem_we=0, mem_a=0, mem_d=0, cpu_q=0.
- CLEAR state:
  - Starts on the first cycle with reset low.
  - Each cycle registers mem_a=counter, mem_d=fill, mem_ce=1, mem_we=1, then counter+1.
  - After counter reaches 2^AW-1 and is written: next cycle state=RUN and clr_busy=0; mem_ce/mem_we return to 0 that cycle.
  - Total clear time is 2^AW cycles plus 1 cycle of state exit.
  - CPU and tape inputs are ignored during CLEAR. Tape writes arriving in CLEAR set tape_ovf.
  - Reset mid-clear restarts the clear at address 0.
- RUN state: all mem_* outputs are registered, giving 1 cycle of latency from inputs.
- Per-cycle grant priority in RUN:
  1. Held tape write.
  2. New tape_wr.
  3. CPU access (cpu_cs).
- One-entry tape holding register:
  - Tape loses only to its own held entry. That is, new tape_wr while the hold is full and being issued: the new write is latched into the hold.
  - If the hold is full and not being issued this cycle, the new write is dropped and tape_ovf is set. Unreachable with one write per cycle, but must be implemented.
- CPU collision with a tape grant:
  - CPU write: buffered in a one-entry CPU holding register. It is issued on the next cycle with no tape grant, ahead of any new CPU access.
  - New CPU access while the CPU hold is full: the CPU hold drains first and the new write is latched behind it.
  - CPU read: not performed; rd_miss increments, saturating at 255.
  - cpu_q holds its previous value.
- cpu_q:
  - Registered copy of mem_q, captured only on cycles after a granted CPU read.
  - CPU read data is valid 2 cycles after cpu_ad/cpu_cs.
- A CPU read to an address with a pending held CPU write returns the held data (forwarding).

Optional Feature:
- ORIC_RAM_PATTERN_EN:
  - Defined: clear fill = (counter[7] ? 8'hFF : 8'h00), reproducing the Oric-1 power-on stripe pattern; CLR_VALUE unused.
  - Undefined: fill = CLR_VALUE.

Decomposition:
- Shared package oric_mem_pkg:
  - State enum {ST_CLEAR, ST_RUN}.
  - RAM_AW=16 and the default CLR_VALUE.
  - Write-request struct {addr, data, valid}, used for both holding registers.
- Sub-module oric_wr_hold: one-entry holding register with load/issue/full/overflow. Instantiated twice (tape, CPU).

Test Plan:
- Release reset with AW=4 → 16 writes of 8'hFF to addresses 0..15 on consecutive cycles; clr_busy falls on cycle 17.
- Assert reset at clear address 9 → next clear begins at 0; clr_busy stays high throughout.
- RUN, simultaneous tape_wr(0x0500,0xAA) and CPU write(0x0600,0x55):
  - cycle+1: mem writes 0x0500=0xAA.
  - cycle+2: mem writes 0x0600=0x55.
  - Readback of both returns the correct data.
- tape_wr and CPU read of 0x0600 collide → rd_miss=1, cpu_q unchanged. Uncontested re-read of 0x0600 returns 0x55 two cycles later.
- tape_wr during CLEAR → tape_ovf=1 and stays set until reset; that write never appears on mem_we.
- With ORIC_RAM_PATTERN_EN: after clear, address 0x007F reads 0x00 and 0x0080 reads 0xFF.

Source files
------------

// File: rtl/oric_mem_pkg.sv
// oric_mem_pkg: shared types and constants for the Oric main RAM sequencer.
package oric_mem_pkg;
  localparam int RAM_AW = 16;
  localparam logic [7:0] CLR_DEFAULT = 8'hFF;
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  typedef struct packed {
    logic [RAM_AW-1:0] addr;
    logic [7:0] data;
    logic valid;
  } wr_req_t;
endpackage

// File: rtl/oric_ram_sequencer_if.sv
// oric_ram_sequencer_if: core, tape writer, RAM macro and status signals around the sequencer.
interface oric_ram_sequencer_if #(parameter int AW = 16);
  logic [AW-1:0] cpu_ad;
  logic [7:0] cpu_d;
  logic cpu_cs;
  logic cpu_we;
  logic [7:0] cpu_q;
  logic [AW-1:0] tape_addr;
  logic [7:0] tape_dout;
  logic tape_wr;
  logic [AW-1:0] mem_a;
  logic [7:0] mem_d;
  logic mem_ce;
  logic mem_we;
  logic [7:0] mem_q;
  logic clr_busy;
  logic tape_ovf;
  logic [7:0] rd_miss;
  modport master (
    input cpu_ad, cpu_d, cpu_cs, cpu_we, tape_addr, tape_dout, tape_wr, mem_q,
    output cpu_q, mem_a, mem_d, mem_ce, mem_we, clr_busy, tape_ovf, rd_miss
  );
  modport slave (
    output cpu_ad, cpu_d, cpu_cs, cpu_we, tape_addr, tape_dout, tape_wr, mem_q,
    input cpu_q, mem_a, mem_d, mem_ce, mem_we, clr_busy, tape_ovf, rd_miss
  );
endinterface

// File: rtl/oric_wr_hold.sv
// oric_wr_hold: one-entry write holding register; a load while issuing refills it in place.
module oric_wr_hold
  import oric_mem_pkg::*;
(
  input logic clk_48,
  input logic reset,
  input logic load,
  input logic issue,
  input wr_req_t din,
  output wr_req_t q,
  output logic full,
  output logic ovf
);
  assign full = q.valid;
  assign ovf = load & q.valid & ~issue;
  always_ff @(posedge clk_48)
    if (reset) q <= '0;
    else if (load && (!q.valid || issue)) q <= din;
    else if (issue) q.valid <= 1'b0;
endmodule

// File: rtl/oric_ram_sequencer.sv
// oric_ram_sequencer: power-on clear and tape/CPU arbitration for the main RAM; ORIC_RAM_PATTERN_EN selects the Oric-1 stripe fill.
module oric_ram_sequencer
  import oric_mem_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter logic [7:0] CLR_VALUE = CLR_DEFAULT
) (
  input logic clk_48,
  input logic reset,
  oric_ram_sequencer_if.master bus
);
  state_t state;
  logic [AW-1:0] cnt;
  logic [7:0] fill, fwd_data;
  logic rd_pend, fwd_pend;
  wr_req_t tape_hq, cpu_hq, tape_new, cpu_new, req;
  logic tape_full, cpu_full, tape_lost, cpu_lost_unused;
  logic run, t_issue, t_direct, tape_gnt, c_issue, c_direct, cpu_wr, cpu_rd, fwd, miss;
`ifdef ORIC_RAM_PATTERN_EN
  assign fill = cnt[7] ? 8'hFF : 8'h00;
`else
  assign fill = CLR_VALUE;
`endif
  assign run = state == ST_RUN;
  assign cpu_wr = bus.cpu_cs & bus.cpu_we;
  assign cpu_rd = bus.cpu_cs & ~bus.cpu_we;
  assign tape_new = '{addr: RAM_AW'(bus.tape_addr), data: bus.tape_dout, valid: 1'b1};
  assign cpu_new = '{addr: RAM_AW'(bus.cpu_ad), data: bus.cpu_d, valid: 1'b1};
  assign t_issue = run & tape_full;
  assign t_direct = run & ~tape_full & bus.tape_wr;
  assign tape_gnt = t_issue | t_direct;
  assign c_issue = run & ~tape_gnt & cpu_full;
  assign c_direct = run & ~tape_gnt & ~cpu_full & bus.cpu_cs;
  // a read hitting the parked CPU write is answered from the hold, no RAM slot needed
  assign fwd = run & cpu_rd & cpu_full & (cpu_hq.addr == RAM_AW'(bus.cpu_ad));
  assign miss = run & cpu_rd & ~c_direct & ~fwd;
  assign req = t_issue ? tape_hq : t_direct ? tape_new : c_issue ? cpu_hq : c_direct ? cpu_new : '0;
  oric_wr_hold u_tape_hold (
    .clk_48(clk_48), .reset(reset), .load(run & bus.tape_wr & tape_full), .issue(t_issue),
    .din(tape_new), .q(tape_hq), .full(tape_full), .ovf(tape_lost)
  );
  oric_wr_hold u_cpu_hold (
    .clk_48(clk_48), .reset(reset), .load(run & cpu_wr & ~c_direct), .issue(c_issue),
    .din(cpu_new), .q(cpu_hq), .full(cpu_full), .ovf(cpu_lost_unused)
  );
  always_ff @(posedge clk_48)
    if (reset) begin
      state <= ST_CLEAR;
      cnt <= '0;
      bus.mem_a <= '0;
      bus.mem_d <= '0;
      bus.mem_ce <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.cpu_q <= '0;
      bus.clr_busy <= 1'b1;
      bus.tape_ovf <= 1'b0;
      bus.rd_miss <= '0;
      rd_pend <= 1'b0;
      fwd_pend <= 1'b0;
      fwd_data <= '0;
    end else if (!run) begin
      bus.mem_a <= cnt;
      bus.mem_d <= fill;
      bus.mem_ce <= 1'b1;
      bus.mem_we <= 1'b1;
      cnt <= cnt + AW'(1);
      state <= &cnt ? ST_RUN : ST_CLEAR;
      bus.tape_ovf <= bus.tape_ovf | bus.tape_wr;
    end else begin
      bus.clr_busy <= 1'b0;
      bus.mem_a <= AW'(req.addr);
      bus.mem_d <= req.data;
      bus.mem_ce <= req.valid;
      bus.mem_we <= req.valid & ~(c_direct & ~bus.cpu_we);
      rd_pend <= c_direct & ~bus.cpu_we;
      fwd_pend <= fwd;
      fwd_data <= cpu_hq.data;
      bus.cpu_q <= fwd_pend ? fwd_data : rd_pend ? bus.mem_q : bus.cpu_q;
      bus.tape_ovf <= bus.tape_ovf | tape_lost;
      bus.rd_miss <= bus.rd_miss + 8'(miss && bus.rd_miss != 8'hFF);
    end
endmodule

// File: tb/tb_oric_ram_sequencer.sv
// tb_oric_ram_sequencer: directed scoreboard bench; ORIC_RAM_PATTERN_EN switches the expected clear fill.
module tb_oric_ram_sequencer;
  localparam int AW = 12;
  logic clk_48 = 1'b0;
  logic reset = 1'b1;
  always #5 clk_48 = ~clk_48;
  oric_ram_sequencer_if #(.AW(AW)) bus();
  oric_ram_sequencer #(.AW(AW)) dut (.clk_48(clk_48), .reset(reset), .bus(bus));

  logic [7:0] ram [0:(1<<AW)-1];
  always @(posedge clk_48) if (bus.mem_ce && bus.mem_we) ram[bus.mem_a] <= bus.mem_d;
  assign bus.mem_q = ram[bus.mem_a];

  int cyc = 0;
  always @(posedge clk_48) cyc++;
  int compared = 0, mismatched = 0;
  typedef struct {int cyc; logic [AW-1:0] a; logic [7:0] d;} exp_t;
  exp_t wr_q[$], rd_q[$];

  function automatic logic [7:0] fill(int k);
`ifdef ORIC_RAM_PATTERN_EN
    return k[7] ? 8'hFF : 8'h00;
`else
    return 8'hFF;
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_wr(int c, int a, int d);
    wr_q.push_back('{c, AW'(a), 8'(d)});
  endtask

  task automatic push_rd(int c, int d);
    rd_q.push_back('{c, '0, 8'(d)});
  endtask

  // monitor: pops expected RAM writes and cpu_q values as the DUT presents them
  always @(negedge clk_48) begin
    exp_t e;
    while (wr_q.size() != 0 && wr_q[0].cyc < cyc) begin
      e = wr_q.pop_front();
      compared++; mismatched++;
      $display("FAIL mem_wr_missing: got no write expected a=%h d=%h at cycle %0d", e.a, e.d, e.cyc);
    end
    if (bus.mem_ce && bus.mem_we) begin
      if (wr_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL mem_wr_unexpected: got a=%h d=%h at cycle %0d expected no write", bus.mem_a, bus.mem_d, cyc);
      end else begin
        e = wr_q.pop_front();
        compared++;
        if (bus.mem_a !== e.a || bus.mem_d !== e.d || cyc != e.cyc) begin
          mismatched++;
          $display("FAIL mem_wr: got a=%h d=%h cyc=%0d expected a=%h d=%h cyc=%0d",
                   bus.mem_a, bus.mem_d, cyc, e.a, e.d, e.cyc);
        end
      end
    end
    if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
      e = rd_q.pop_front();
      chk("cpu_q", {24'd0, bus.cpu_q}, {24'd0, e.d});
    end
  end

  task automatic tick();
    @(posedge clk_48);
    #1;
  endtask

  task automatic idle();
    bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0; bus.tape_wr = 1'b0;
  endtask

  task automatic tape(int a, int d);
    bus.tape_wr = 1'b1; bus.tape_addr = AW'(a); bus.tape_dout = 8'(d);
  endtask

  task automatic cpu(logic we, int a, int d);
    bus.cpu_cs = 1'b1; bus.cpu_we = we; bus.cpu_ad = AW'(a); bus.cpu_d = 8'(d);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base, t;
    idle();
    bus.cpu_ad = '0; bus.cpu_d = '0; bus.tape_addr = '0; bus.tape_dout = '0;
    repeat (3) tick();
    chk("rst_clr_busy", bus.clr_busy, 1);
    chk("rst_mem_ce", bus.mem_ce, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_a", bus.mem_a, 0);
    chk("rst_cpu_q", bus.cpu_q, 0);
    chk("rst_tape_ovf", bus.tape_ovf, 0);
    chk("rst_rd_miss", bus.rd_miss, 0);
    // clear interrupted by reset right after address 9
    reset = 1'b0;
    base = cyc;
    for (int k = 0; k < 10; k++) push_wr(base + 1 + k, k, fill(k));
    repeat (10) tick();
    chk("clr_busy_mid", bus.clr_busy, 1);
    chk("clr_addr9", bus.mem_a, 9);
    reset = 1'b1;
    tick();
    chk("rst_mid_ce", bus.mem_ce, 0);
    chk("rst_mid_busy", bus.clr_busy, 1);
    chk("rst_mid_a", bus.mem_a, 0);
    tick();
    // full clear, restarting at address 0
    reset = 1'b0;
    base = cyc;
    for (int k = 0; k < (1 << AW); k++) push_wr(base + 1 + k, k, fill(k));
    repeat (100) tick();
    tape(12'h123, 8'h5A);
    cpu(1'b1, 12'h124, 8'h66);
    tick();
    idle();
    chk("tape_ovf_set", bus.tape_ovf, 1);
    while (cyc < base + (1 << AW)) tick();
    chk("clr_busy_last", bus.clr_busy, 1);
    chk("tape_ovf_sticky", bus.tape_ovf, 1);
    tick();
    chk("clr_busy_fall", bus.clr_busy, 0);
    chk("clr_exit_ce", bus.mem_ce, 0);
    // simultaneous tape and CPU write
    t = cyc;
    tape(12'h500, 8'hAA);
    cpu(1'b1, 12'h600, 8'h55);
    push_wr(t + 1, 12'h500, 8'hAA);
    push_wr(t + 2, 12'h600, 8'h55);
    tick();
    idle();
    repeat (2) tick();
    // readback, back to back
    t = cyc;
    cpu(1'b0, 12'h600, 0);
    push_rd(t + 2, 8'h55);
    tick();
    cpu(1'b0, 12'h500, 0);
    push_rd(t + 3, 8'hAA);
    tick();
    idle();
    repeat (2) tick();
    // CPU read displaced by tape write
    t = cyc;
    tape(12'h700, 8'h11);
    cpu(1'b0, 12'h600, 0);
    push_wr(t + 1, 12'h700, 8'h11);
    push_rd(t + 2, 8'hAA);
    tick();
    idle();
    chk("rd_miss_one", bus.rd_miss, 1);
    tick();
    t = cyc;
    cpu(1'b0, 12'h600, 0);
    push_rd(t + 2, 8'h55);
    tick();
    idle();
    repeat (2) tick();
    // read forwarded from the parked CPU write
    t = cyc;
    tape(12'h710, 8'h22);
    cpu(1'b1, 12'h800, 8'h77);
    push_wr(t + 1, 12'h710, 8'h22);
    push_wr(t + 2, 12'h800, 8'h77);
    tick();
    bus.tape_wr = 1'b0;
    cpu(1'b0, 12'h800, 0);
    push_rd(t + 3, 8'h77);
    tick();
    idle();
    repeat (2) tick();
    chk("rd_miss_fwd", bus.rd_miss, 1);
    // CPU hold drains ahead of the next CPU write
    t = cyc;
    tape(12'h720, 8'h33);
    cpu(1'b1, 12'hA00, 8'h01);
    push_wr(t + 1, 12'h720, 8'h33);
    push_wr(t + 2, 12'hA00, 8'h01);
    tick();
    bus.tape_wr = 1'b0;
    cpu(1'b1, 12'hA01, 8'h02);
    push_wr(t + 3, 12'hA01, 8'h02);
    tick();
    idle();
    repeat (2) tick();
    // clear fill around the stripe boundary
    t = cyc;
    cpu(1'b0, 12'h07F, 0);
    push_rd(t + 2, fill(12'h07F));
    tick();
    cpu(1'b0, 12'h080, 0);
    push_rd(t + 3, fill(12'h080));
    tick();
    idle();
    repeat (2) tick();
    // rd_miss saturation under a continuous tape stream
    t = cyc;
    for (int i = 0; i < 256; i++) begin
      tape(12'hB00 + i, i);
      cpu(1'b0, 12'h000, 0);
      push_wr(t + 1 + i, 12'hB00 + i, i);
      tick();
    end
    idle();
    chk("rd_miss_sat", bus.rd_miss, 255);
    repeat (4) tick();
    chk("wr_q_drained", wr_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
